// File: rtl/irq_pkg.sv
// Shared types and default register/vector constants for the interrupt context sequencer.
package irq_pkg;

  localparam int          DATA_W_DEF     = 32;
  localparam int          ADDR_W_DEF     = 4;
  localparam logic [3:0]  PC_REG_DEF     = 4'd12;
  localparam logic [3:0]  FLAG_REG_DEF   = 4'd13;
  localparam logic [31:0] IRQ_VECTOR_DEF = 32'h0000_0040;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_SAVE_PC,
    ST_SAVE_FLAGS,
    ST_VECTOR,
    ST_HANDLER,
    ST_RST_FLAGS,
    ST_RST_PC
  } irq_state_t;

endpackage

// File: rtl/irq_context_sequencer.sv
// Owns the regfile write port and a context read port: saves PC/flags on interrupt entry,
// restores them on IRET, and stalls the pipeline while either sequence runs.
module irq_context_sequencer
  import irq_pkg::*;
#(
  parameter int                 DATA_W     = DATA_W_DEF,
  parameter int                 ADDR_W     = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0]  PC_REG     = PC_REG_DEF,
  parameter logic [ADDR_W-1:0]  FLAG_REG   = FLAG_REG_DEF,
  parameter logic [DATA_W-1:0]  IRQ_VECTOR = IRQ_VECTOR_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              irq_req,
  input  logic              iret_req,
  input  logic [DATA_W-1:0] pc_ex,
  input  logic [1:0]        flags_in,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              wb_set,
  input  logic              wb_reset,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic              rf_is_set,
  output logic              rf_is_reset,
  output logic [ADDR_W-1:0] rf_ra,
  output logic              stall,
  output logic              pc_redirect,
  output logic [DATA_W-1:0] pc_target,
  output logic [1:0]        flags_out,
  output logic              flags_load,
  output logic              in_handler,
  output logic              wb_conflict
);

  irq_state_t        state;
  logic              irq_q;
  logic              irq_pending;
  logic              irq_edge;
  logic [DATA_W-1:0] saved_pc;
  logic [1:0]        saved_flags;
  logic [DATA_W-1:0] pc_target_q;

  assign irq_edge = irq_req & ~irq_q;

  // The return address is read combinationally from r12 during the final restore cycle.
  assign pc_target = (state == ST_RST_PC) ? rf_rdata : pc_target_q;

  always_comb begin
    rf_we       = 1'b0;
    rf_wa       = '0;
    rf_wd       = '0;
    rf_is_set   = 1'b0;
    rf_is_reset = 1'b0;
    if (!rst) begin
      case (state)
        ST_IDLE, ST_DRAIN, ST_HANDLER: begin
          rf_we       = wb_en;
          rf_wa       = wb_rd;
          rf_wd       = wb_data;
          rf_is_set   = wb_set;
          rf_is_reset = wb_reset;
        end
        ST_SAVE_PC: begin
          rf_we = 1'b1;
          rf_wa = PC_REG;
          rf_wd = saved_pc;
        end
        ST_SAVE_FLAGS: begin
          rf_we = 1'b1;
          rf_wa = FLAG_REG;
          rf_wd = {{(DATA_W-2){1'b0}}, saved_flags};
        end
        default: ;
      endcase
    end
  end

  // Outputs are registered for the state being entered, so they line up with that state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      irq_q       <= 1'b0;
      irq_pending <= 1'b0;
      saved_pc    <= '0;
      saved_flags <= '0;
      pc_target_q <= '0;
      flags_out   <= '0;
      rf_ra       <= '0;
      stall       <= 1'b0;
      pc_redirect <= 1'b0;
      flags_load  <= 1'b0;
      in_handler  <= 1'b0;
      wb_conflict <= 1'b0;
    end else begin
      irq_q       <= irq_req;
      stall       <= 1'b0;
      pc_redirect <= 1'b0;
      flags_load  <= 1'b0;
      in_handler  <= 1'b0;
      rf_ra       <= '0;
      if (irq_edge && !irq_pending && state != ST_IDLE) irq_pending <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (irq_edge || irq_pending) begin
            state       <= ST_DRAIN;
            stall       <= 1'b1;
            saved_pc    <= pc_ex;
            saved_flags <= flags_in;
            irq_pending <= 1'b0;
          end
        end
        ST_DRAIN: begin
          state <= ST_SAVE_PC;
          stall <= 1'b1;
        end
        ST_SAVE_PC: begin
          state <= ST_SAVE_FLAGS;
          stall <= 1'b1;
          if (wb_en) wb_conflict <= 1'b1;
        end
        ST_SAVE_FLAGS: begin
          state       <= ST_VECTOR;
          stall       <= 1'b1;
          pc_redirect <= 1'b1;
          pc_target_q <= IRQ_VECTOR;
          if (wb_en) wb_conflict <= 1'b1;
        end
        ST_VECTOR: begin
          state      <= ST_HANDLER;
          in_handler <= 1'b1;
        end
        ST_HANDLER: begin
          in_handler <= 1'b1;
          if (iret_req) begin
            state <= ST_RST_FLAGS;
            stall <= 1'b1;
            rf_ra <= FLAG_REG;
          end
        end
        ST_RST_FLAGS: begin
          state       <= ST_RST_PC;
          stall       <= 1'b1;
          in_handler  <= 1'b1;
          rf_ra       <= PC_REG;
          pc_redirect <= 1'b1;
          flags_out   <= rf_rdata[1:0];
          flags_load  <= 1'b1;
        end
        ST_RST_PC: begin
          state       <= ST_IDLE;
          pc_target_q <= rf_rdata;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_context_sequencer.sv
// Bench for irq_context_sequencer: a transaction-level model expands each entry/return
// into its expected cycle script and is compared with the DUT on every cycle.
module tb_irq_context_sequencer;

  typedef struct packed {
    logic        stall;
    logic        pass;
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [3:0]  ra;
    logic        redirect;
    logic [31:0] target;
    logic        fload;
    logic [1:0]  flags;
    logic        in_h;
  } cyc_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        irq_req, iret_req;
  logic [31:0] pc_ex;
  logic [1:0]  flags_in;
  logic        wb_en, wb_set, wb_reset;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] rf_rdata;
  logic        rf_we, rf_is_set, rf_is_reset;
  logic [3:0]  rf_wa, rf_ra;
  logic [31:0] rf_wd, pc_target;
  logic        stall, pc_redirect, flags_load, in_handler, wb_conflict;
  logic [1:0]  flags_out;

  // clock / reset block
  always #5 clk = ~clk;

  irq_context_sequencer dut (
    .clk(clk), .rst(rst), .irq_req(irq_req), .iret_req(iret_req), .pc_ex(pc_ex),
    .flags_in(flags_in), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_set(wb_set), .wb_reset(wb_reset), .rf_rdata(rf_rdata), .rf_we(rf_we),
    .rf_wa(rf_wa), .rf_wd(rf_wd), .rf_is_set(rf_is_set), .rf_is_reset(rf_is_reset),
    .rf_ra(rf_ra), .stall(stall), .pc_redirect(pc_redirect), .pc_target(pc_target),
    .flags_out(flags_out), .flags_load(flags_load), .in_handler(in_handler),
    .wb_conflict(wb_conflict)
  );

  // register file the sequencer drives
  logic [31:0] rf [16] = '{default: '0};
  assign rf_rdata = rf[rf_ra];
  always @(posedge clk)
    if (rf_we)
      rf[rf_wa] <= rf_is_set ? (rf[rf_wa] | rf_wd) : rf_is_reset ? (rf[rf_wa] & rf_wd) : rf_wd;

  // scoreboard and model state
  cyc_t        exp_q[$];
  logic [31:0] shadow [16] = '{default: '0};
  logic        m_handler = 1'b0, m_pending = 1'b0, m_irq_prev = 1'b0;
  logic        m_conflict = 1'b0, m_rst_prev = 1'b0;
  logic [31:0] m_tgt = '0;
  logic [1:0]  m_flg = '0;
  int          n_cmp = 0, n_err = 0;
  int          stall_cnt = 0, fload_cnt = 0, vec_cnt = 0;
  logic [31:0] last_tgt = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic cyc_t base_rec();
    cyc_t r;
    r        = '0;
    r.pass   = 1'b1;
    r.in_h   = m_handler;
    r.target = m_tgt;
    r.flags  = m_flg;
    return r;
  endfunction

  task automatic push_entry();
    cyc_t r;
    r = base_rec(); r.in_h = 1'b0; r.stall = 1'b1;
    exp_q.push_back(r);
    r.pass = 1'b0; r.we = 1'b1; r.wa = 4'd12; r.wd = pc_ex;
    exp_q.push_back(r);
    r.wa = 4'd13; r.wd = {30'b0, flags_in};
    exp_q.push_back(r);
    r.we = 1'b0; r.wa = '0; r.wd = '0; r.redirect = 1'b1; r.target = 32'h40;
    exp_q.push_back(r);
    m_tgt     = 32'h40;
    m_handler = 1'b1;
  endtask

  task automatic push_return();
    cyc_t r;
    r = base_rec(); r.pass = 1'b0; r.stall = 1'b1; r.in_h = 1'b1; r.ra = 4'd13;
    exp_q.push_back(r);
    r.ra = 4'd12; r.redirect = 1'b1; r.target = shadow[12];
    r.fload = 1'b1; r.flags = shadow[13][1:0];
    exp_q.push_back(r);
    m_tgt     = shadow[12];
    m_flg     = shadow[13][1:0];
    m_handler = 1'b0;
  endtask

  task automatic model_step();
    cyc_t cur;
    logic exp_we, edge_v, entry_now, busy;
    if (stall === 1'b1) stall_cnt++;
    if (flags_load === 1'b1) fload_cnt++;
    if (pc_redirect === 1'b1) begin
      last_tgt = pc_target;
      if (pc_target == 32'h40) vec_cnt++;
    end
    if (rst) begin
      check("rst_rf_we", 32'(rf_we), 32'd0);
      check("rst_rf_set_reset", 32'({rf_is_set, rf_is_reset}), 32'd0);
      if (m_rst_prev) begin
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_redirect", 32'(pc_redirect), 32'd0);
        check("rst_target", pc_target, 32'd0);
        check("rst_flags", 32'({flags_out, flags_load}), 32'd0);
        check("rst_in_handler", 32'(in_handler), 32'd0);
        check("rst_conflict", 32'(wb_conflict), 32'd0);
        check("rst_ra", 32'(rf_ra), 32'd0);
      end
      exp_q.delete();
      m_handler = 0; m_pending = 0; m_irq_prev = 0; m_conflict = 0;
      m_tgt = '0; m_flg = '0; m_rst_prev = 1'b1;
      return;
    end
    m_rst_prev = 1'b0;
    cur = (exp_q.size() > 0) ? exp_q[0] : base_rec();
    exp_we = cur.pass ? wb_en : cur.we;
    check("rf_we", 32'(rf_we), 32'(exp_we));
    if (exp_we) begin
      check("rf_wa", 32'(rf_wa), 32'(cur.pass ? wb_rd : cur.wa));
      check("rf_wd", rf_wd, cur.pass ? wb_data : cur.wd);
      check("rf_is_set", 32'(rf_is_set), 32'(cur.pass & wb_set));
      check("rf_is_reset", 32'(rf_is_reset), 32'(cur.pass & wb_reset));
    end
    check("stall", 32'(stall), 32'(cur.stall));
    check("pc_redirect", 32'(pc_redirect), 32'(cur.redirect));
    check("pc_target", pc_target, cur.target);
    check("flags_out", 32'(flags_out), 32'(cur.flags));
    check("flags_load", 32'(flags_load), 32'(cur.fload));
    check("in_handler", 32'(in_handler), 32'(cur.in_h));
    check("rf_ra", 32'(rf_ra), 32'(cur.ra));
    check("wb_conflict", 32'(wb_conflict), 32'(m_conflict));
    // advance the model across the coming clock edge
    edge_v = irq_req & ~m_irq_prev;
    m_irq_prev = irq_req;
    if (cur.pass && wb_en)
      shadow[wb_rd] = wb_set ? (shadow[wb_rd] | wb_data) :
                      wb_reset ? (shadow[wb_rd] & wb_data) : wb_data;
    else if (cur.we) begin
      shadow[cur.wa] = cur.wd;
      if (wb_en) m_conflict = 1'b1;
    end
    busy = (exp_q.size() > 0);
    if (busy) void'(exp_q.pop_front());
    entry_now = 1'b0;
    if (!busy) begin
      if (!m_handler) begin
        if (edge_v || m_pending) begin
          push_entry();
          m_pending = 1'b0;
          entry_now = 1'b1;
        end
      end else if (iret_req) push_return();
    end
    if (edge_v && !entry_now && !m_pending) m_pending = 1'b1;
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_in_handler(input logic want, input int max_cyc, input string tag);
    int n = 0;
    while (in_handler !== want && n < max_cyc) begin
      tick();
      n++;
    end
    check(tag, 32'(in_handler), 32'(want));
  endtask

  task automatic do_iret();
    iret_req = 1'b1;
    tick();
    iret_req = 1'b0;
    wait_in_handler(1'b0, 10, "return_timeout");
  endtask

  initial begin
    int s0, f0, v0;
    rst = 1'b1; irq_req = 0; iret_req = 0; pc_ex = '0; flags_in = '0;
    wb_en = 0; wb_rd = '0; wb_data = '0; wb_set = 0; wb_reset = 0;
    fork
      forever begin
        @(negedge clk);
        model_step();
      end
    join_none
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // entry: PC 0x100, flags 2'b10
    s0 = stall_cnt;
    pc_ex = 32'h100; flags_in = 2'b10; irq_req = 1'b1;
    tick();
    pc_ex = 32'h200; flags_in = 2'b01;
    wait_in_handler(1'b1, 20, "entry_timeout");
    irq_req = 1'b0;
    check("entry_stall_cycles", 32'(stall_cnt - s0), 32'd4);
    check("entry_vector", last_tgt, 32'h40);
    check("saved_r12", rf[12], 32'h100);
    check("saved_r13", rf[13], 32'h2);

    // handler-time writeback including an OR-write
    wb_en = 1'b1; wb_rd = 4'd6; wb_data = 32'h0F;
    tick();
    wb_set = 1'b1; wb_data = 32'hF0;
    tick();
    wb_en = 1'b0; wb_set = 1'b0;
    check("or_write_r6", rf[6], 32'hFF);

    // return
    s0 = stall_cnt; f0 = fload_cnt;
    do_iret();
    check("return_stall_cycles", 32'(stall_cnt - s0), 32'd2);
    check("return_target", last_tgt, 32'h100);
    check("return_flags", 32'(flags_out), 32'd2);
    check("return_flags_load", 32'(fload_cnt - f0), 32'd1);

    // drain: WB writes on the edge cycle and in DRAIN both land
    wb_en = 1'b1; wb_rd = 4'd3; wb_data = 32'd7; irq_req = 1'b1;
    tick();
    wb_rd = 4'd4; wb_data = 32'h11;
    tick();
    wb_en = 1'b0;
    check("drain_r3", rf[3], 32'd7);
    check("drain_r4", rf[4], 32'h11);
    wait_in_handler(1'b1, 20, "drain_entry_timeout");
    irq_req = 1'b0;
    do_iret();
    check("drain_return_flags", 32'(flags_out), 32'd1);

    // collision: edge in HANDLER goes pending, edge in RST_PC is dropped
    pc_ex = 32'h300; irq_req = 1'b1;
    tick();
    irq_req = 1'b0;
    wait_in_handler(1'b1, 20, "coll_entry_timeout");
    v0 = vec_cnt;
    irq_req = 1'b1;
    tick();
    irq_req = 1'b0;
    tick();
    iret_req = 1'b1;
    tick();
    iret_req = 1'b0;
    tick();
    irq_req = 1'b1;
    tick();
    irq_req = 1'b0;
    wait_in_handler(1'b1, 20, "coll_reentry_timeout");
    repeat (10) tick();
    check("coll_reentries", 32'(vec_cnt - v0), 32'd1);
    do_iret();
    repeat (4) tick();
    check("coll_no_second", 32'(vec_cnt - v0), 32'd1);

    // conflict: WB during SAVE_PC is dropped and flagged
    check("conflict_clear", 32'(wb_conflict), 32'd0);
    irq_req = 1'b1;
    tick();
    tick();
    wb_en = 1'b1; wb_rd = 4'd5; wb_data = 32'hDEAD;
    @(negedge clk);
    check("conflict_wa", 32'(rf_wa), 32'd12);
    check("conflict_wd", rf_wd, 32'h300);
    tick();
    wb_en = 1'b0; irq_req = 1'b0;
    wait_in_handler(1'b1, 20, "conflict_entry_timeout");
    check("conflict_set", 32'(wb_conflict), 32'd1);
    check("conflict_r5_kept", rf[5], 32'd0);
    do_iret();
    tick();
    check("conflict_sticky", 32'(wb_conflict), 32'd1);

    // reset for two cycles mid-handler
    irq_req = 1'b1;
    tick();
    irq_req = 1'b0;
    wait_in_handler(1'b1, 20, "rst_entry_timeout");
    rst = 1'b1; wb_en = 1'b1; wb_rd = 4'd7; wb_data = 32'h55;
    tick();
    tick();
    check("rst_hold_in_handler", 32'(in_handler), 32'd0);
    check("rst_hold_stall", 32'(stall), 32'd0);
    check("rst_hold_conflict", 32'(wb_conflict), 32'd0);
    check("rst_hold_we", 32'(rf_we), 32'd0);
    rst = 1'b0; wb_en = 1'b0;
    v0 = vec_cnt;
    repeat (5) tick();
    check("post_rst_idle", 32'(in_handler), 32'd0);
    check("post_rst_no_redirect", 32'(vec_cnt - v0), 32'd0);
    check("post_rst_r7", rf[7], 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
